// File: rtl/display_pager_pkg.sv
// Shared types and constants for the seven-segment display pager.
package display_pager_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  typedef enum logic [1:0] {
    PG_TIME = 2'd0,
    PG_SEC  = 2'd1,
    PG_WDAY = 2'd2,
    PG_YEAR = 2'd3
  } page_t;

  // Active-low segments, bit order GFEDCBA.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_TWO   = 7'h24;

  // Two glyphs per weekday; element [1] is the left character.
  typedef logic [1:0][6:0] wday_glyphs_t;

  // Mo, tu, WE, th, Fr, SA, So. "M" and "W" are the usual seven-segment
  // approximations (inverted U and U).
  localparam wday_glyphs_t WDAY_GLYPHS [8] = '{
    {SEG_DASH, SEG_DASH},   // 0: no weekday
    {7'h48,    7'h23},      // 1: Mo
    {7'h07,    7'h63},      // 2: tu
    {7'h41,    7'h06},      // 3: WE
    {7'h07,    7'h0B},      // 4: th
    {7'h0E,    7'h2F},      // 5: Fr
    {7'h12,    7'h08},      // 6: SA
    {7'h12,    7'h23}       // 7: So
  };

  // Weekday codes above 7 are not valid and show as dashes.
  function automatic wday_glyphs_t wday_glyphs(input bcd_t dow);
    return (dow > 4'd7) ? {SEG_DASH, SEG_DASH} : WDAY_GLYPHS[dow[2:0]];
  endfunction

  // Auto-rotation order: TIME -> WDAY -> YEAR -> TIME; SEC is skipped.
  function automatic page_t next_auto_page(input page_t pg);
    case (pg)
      PG_TIME: return PG_WDAY;
      PG_WDAY: return PG_YEAR;
      default: return PG_TIME;
    endcase
  endfunction

endpackage

// File: rtl/display_pager_if.sv
// BCD date/time bundle published by the clock module.
interface if_date_time;
  import display_pager_pkg::*;

  bcd_pair_t second;
  bcd_pair_t minute;
  bcd_pair_t hour;
  bcd_pair_t day;
  bcd_pair_t month;
  bcd_pair_t year;
  bcd_t      day_of_week;

  modport master (output second, minute, hour, day, month, year, day_of_week);
  modport slave  (input  second, minute, hour, day, month, year, day_of_week);
endinterface

// File: rtl/display_pager_seg7_glyph.sv
// BCD digit to active-low seven-segment glyph; non-decimal nibbles show a dash.
module seg7_glyph
  import display_pager_pkg::*;
(
  input  bcd_t       digit_i,
  output logic [6:0] seg_o
);

  // Standard decimal glyph lookup with dash for invalid BCD.
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_pager.sv
// Multi-page seven-segment driver: manual/auto page selection, unsync blink,
// hour leading-zero blanking and registered active-low outputs.
module display_pager
  import display_pager_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DWELL_S     = 4,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_1hz,
  input  logic                     sync_ok,
  input  logic [3:0]               sw,
  if_date_time.slave               clock,
  output logic [N_DIGITS-1:0][6:0] hex,
  output page_t                    page
);

  if (N_DIGITS != 4 && N_DIGITS != 6) begin : g_bad_digits
    $error("display_pager: N_DIGITS must be 4 or 6");
  end
  if (DWELL_S < 1 || DWELL_S > 15) begin : g_bad_dwell
    $error("display_pager: DWELL_S must be in 1..15");
  end

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_S - 1);

  // Numeric field positions feeding the glyph decoders.
  localparam int FD_HT = 0, FD_HO = 1, FD_MT = 2, FD_MO = 3;
  localparam int FD_ST = 4, FD_SO = 5, FD_DT = 6, FD_DO = 7;
  localparam int FD_NT = 8, FD_NO = 9, FD_YT = 10, FD_YO = 11;
  localparam int N_FIELDS = 12;

  page_t                    page_q, page_d;
  logic [3:0]               dwell_q, dwell_d;
  logic                     phase_q;
  logic                     auto_q;
  logic [N_DIGITS-1:0][6:0] hex_q, hex_d;

  page_t        manual_page;
  bcd_t         num_digit [N_FIELDS];
  logic [6:0]   num_seg   [N_FIELDS];
  wday_glyphs_t wday_seg;
  logic [6:0]   lm        [6];     // glyphs leftmost first
  logic         blank_now;

  assign num_digit = '{clock.hour.tens,   clock.hour.ones,
                       clock.minute.tens, clock.minute.ones,
                       clock.second.tens, clock.second.ones,
                       clock.day.tens,    clock.day.ones,
                       clock.month.tens,  clock.month.ones,
                       clock.year.tens,   clock.year.ones};

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_glyph
    seg7_glyph u_glyph (
      .digit_i (num_digit[i]),
      .seg_o   (num_seg[i])
    );
  end

  assign wday_seg = wday_glyphs(clock.day_of_week);

  // Manual page select, sw[0] has highest priority.
  always_comb begin
    if (sw[0])      manual_page = PG_SEC;
    else if (sw[1]) manual_page = PG_WDAY;
    else if (sw[2]) manual_page = PG_YEAR;
    else            manual_page = PG_TIME;
  end

  // Page state register, dwell counter, mode history and blink phase.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q  <= PG_TIME;
      dwell_q <= '0;
      auto_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      page_q  <= page_d;
      dwell_q <= dwell_d;
      auto_q  <= sw[3];
      if (tick_1hz) phase_q <= ~phase_q;
    end
  end

  // Next page and dwell count; a mode change overrides a coincident tick.
  // NOTE: defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    page_d  = page_q;
    dwell_d = dwell_q;
    if (sw[3] != auto_q) begin
      dwell_d = '0;
      if (sw[3]) page_d = (page_q == PG_SEC) ? PG_TIME : page_q;
      else       page_d = manual_page;
    end else if (sw[3]) begin
      if (tick_1hz) begin
        if (dwell_q == DWELL_LAST) begin
          page_d  = next_auto_page(page_q);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
    end else begin
      page_d  = manual_page;
      dwell_d = '0;
    end
  end

  assign blank_now = !sync_ok && phase_q;

  // Compose the current page leftmost-first, then map onto hex digits.
  always_comb begin
    for (int i = 0; i < 6; i++) lm[i] = SEG_BLANK;
    case (page_q)
      PG_TIME: begin
        lm[0] = (LZ_SUPPRESS && clock.hour.tens == 4'd0) ? SEG_BLANK : num_seg[FD_HT];
        lm[1] = num_seg[FD_HO];
        lm[2] = num_seg[FD_MT];
        lm[3] = num_seg[FD_MO];
        lm[4] = num_seg[FD_ST];
        lm[5] = num_seg[FD_SO];
      end
      PG_SEC: begin
        lm[N_DIGITS-2] = num_seg[FD_ST];
        lm[N_DIGITS-1] = num_seg[FD_SO];
      end
      PG_WDAY: begin
        lm[0] = wday_seg[1];
        lm[1] = wday_seg[0];
        lm[2] = num_seg[FD_DT];
        lm[3] = num_seg[FD_DO];
        lm[4] = num_seg[FD_NT];
        lm[5] = num_seg[FD_NO];
      end
      default: begin
        if (N_DIGITS == 6) begin
          lm[0] = SEG_TWO;
          lm[1] = SEG_ZERO;
          lm[2] = num_seg[FD_YT];
          lm[3] = num_seg[FD_YO];
          lm[4] = num_seg[FD_NT];
          lm[5] = num_seg[FD_NO];
        end else begin
          lm[0] = num_seg[FD_YT];
          lm[1] = num_seg[FD_YO];
          lm[2] = num_seg[FD_NT];
          lm[3] = num_seg[FD_NO];
        end
      end
    endcase
    hex_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      hex_d[N_DIGITS-1-i] = blank_now ? SEG_BLANK : lm[i];
    end
  end

  // Output register: reset shows a blank display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hex_q <= {N_DIGITS{SEG_BLANK}};
    else       hex_q <= hex_d;
  end

  assign hex  = hex_q;
  assign page = page_q;

endmodule

// File: tb/tb_display_pager.sv
// Self-checking bench for display_pager: 4- and 6-digit instances share the
// same stimulus; a page/blink model predicts every registered output.
module tb_display_pager;
  import display_pager_pkg::*;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        sync_ok = 1'b1;
  logic [3:0]  sw = 4'b0000;
  logic [27:0] hex4;
  logic [41:0] hex6;
  page_t       page4, page6;

  int checks = 0;
  int errors = 0;

  if_date_time dt ();

  display_pager #(.N_DIGITS(4), .DWELL_S(DWELL), .LZ_SUPPRESS(1'b1)) dut4 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sync_ok(sync_ok),
    .sw(sw), .clock(dt), .hex(hex4), .page(page4)
  );

  display_pager #(.N_DIGITS(6), .DWELL_S(DWELL), .LZ_SUPPRESS(1'b1)) dut6 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sync_ok(sync_ok),
    .sw(sw), .clock(dt), .hex(hex6), .page(page6)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  DIGIT_GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                     7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [13:0] WDAY_GLYPH [8] = '{{7'h3F, 7'h3F}, {7'h48, 7'h23}, {7'h07, 7'h63},
                                  {7'h41, 7'h06}, {7'h07, 7'h0B}, {7'h0E, 7'h2F},
                                  {7'h12, 7'h08}, {7'h12, 7'h23}};
  page_t ROT [3] = '{PG_TIME, PG_WDAY, PG_YEAR};

  page_t m_page;
  int    m_rot;      // index into ROT while rotating
  int    m_ticks;    // ticks spent on the current auto page
  bit    m_phase;
  bit    m_auto;
  logic [41:0] exp4, exp6;

  function automatic logic [6:0] g(input logic [3:0] v);
    return (v > 4'd9) ? 7'h3F : DIGIT_GLYPH[v];
  endfunction

  function automatic logic [41:0] model_hex(input int n, input page_t pg, input bit blank);
    logic [6:0]  d [6];
    logic [13:0] wd;
    logic [41:0] r;
    for (int i = 0; i < 6; i++) d[i] = 7'h7F;
    wd = (dt.day_of_week > 4'd7) ? {7'h3F, 7'h3F} : WDAY_GLYPH[dt.day_of_week[2:0]];
    case (pg)
      PG_TIME: begin
        d[0] = (dt.hour.tens == 4'd0) ? 7'h7F : g(dt.hour.tens);
        d[1] = g(dt.hour.ones);   d[2] = g(dt.minute.tens); d[3] = g(dt.minute.ones);
        d[4] = g(dt.second.tens); d[5] = g(dt.second.ones);
      end
      PG_SEC: begin
        d[n-2] = g(dt.second.tens); d[n-1] = g(dt.second.ones);
      end
      PG_WDAY: begin
        d[0] = wd[13:7];         d[1] = wd[6:0];
        d[2] = g(dt.day.tens);   d[3] = g(dt.day.ones);
        d[4] = g(dt.month.tens); d[5] = g(dt.month.ones);
      end
      default: begin
        if (n == 6) begin
          d[0] = 7'h24; d[1] = 7'h40;
          d[2] = g(dt.year.tens);  d[3] = g(dt.year.ones);
          d[4] = g(dt.month.tens); d[5] = g(dt.month.ones);
        end else begin
          d[0] = g(dt.year.tens);  d[1] = g(dt.year.ones);
          d[2] = g(dt.month.tens); d[3] = g(dt.month.ones);
        end
      end
    endcase
    r = '0;
    for (int i = 0; i < n; i++) r[(n-1-i)*7 +: 7] = blank ? 7'h7F : d[i];
    return r;
  endfunction

  function automatic page_t manual_choice(input logic [3:0] s);
    if (s[0]) return PG_SEC;
    if (s[1]) return PG_WDAY;
    if (s[2]) return PG_YEAR;
    return PG_TIME;
  endfunction

  // Predict and compare every cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_page = PG_TIME; m_rot = 0; m_ticks = 0; m_phase = 0; m_auto = 0;
      exp4 = model_hex(4, PG_TIME, 1'b1);
      exp6 = model_hex(6, PG_TIME, 1'b1);
    end else begin
      exp4 = model_hex(4, m_page, !sync_ok && m_phase);
      exp6 = model_hex(6, m_page, !sync_ok && m_phase);
      if (sw[3] != m_auto) begin
        m_ticks = 0;
        if (sw[3]) begin
          m_rot  = (m_page == PG_WDAY) ? 1 : (m_page == PG_YEAR) ? 2 : 0;
          m_page = ROT[m_rot];
        end else begin
          m_page = manual_choice(sw);
        end
      end else if (sw[3]) begin
        if (tick_1hz) begin
          m_ticks++;
          if (m_ticks == DWELL) begin
            m_ticks = 0;
            m_rot   = (m_rot + 1) % 3;
          end
        end
        m_page = ROT[m_rot];
      end else begin
        m_page = manual_choice(sw);
      end
      m_auto = sw[3];
      if (tick_1hz) m_phase = ~m_phase;
    end
    #1;
    check("hex4", 64'(hex4), 64'(exp4));
    check("hex6", 64'(hex6), 64'(exp6));
    check("page4", 64'(page4), 64'(m_page));
    check("page6", 64'(page6), 64'(m_page));
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    cycles(2);
  endtask

  initial begin
    dt.hour = 8'h12; dt.minute = 8'h34; dt.second = 8'h56;
    dt.day = 8'h07;  dt.month = 8'h03;  dt.year = 8'h24;
    dt.day_of_week = 4'd2;

    #1 reset = 1'b1;
    #1 check("reset_blank4", 64'(hex4), 64'(28'hFFFFFFF));
    cycles(2);
    reset = 1'b0;
    cycles(1);
    check("time_1234", 64'(hex4), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    // Manual priority.
    sw = 4'b0110;
    cycles(2);
    check("man_wday_page", 64'(page4), 64'(PG_WDAY));
    check("man_wday_hex", 64'(hex4), 64'({7'h07, 7'h63, 7'h40, 7'h78}));
    sw = 4'b0111;
    cycles(2);
    check("man_sec_hex", 64'(hex4), 64'({7'h7F, 7'h7F, 7'h12, 7'h02}));

    // Auto rotation entered from PG_SEC starts at PG_TIME.
    sw = 4'b1000;
    cycles(1);
    for (int k = 1; k <= 13; k++) begin
      pulse_tick();
      if (k == 3)  check("auto_t3", 64'(page4), 64'(PG_TIME));
      if (k == 4)  check("auto_t4", 64'(page4), 64'(PG_WDAY));
      if (k == 8)  check("auto_t8", 64'(page4), 64'(PG_YEAR));
      if (k == 12) check("auto_t12", 64'(page4), 64'(PG_TIME));
    end

    // Leave auto on a tick edge, re-enter: the count restarts.
    pulse_tick();
    sw = 4'b0000; tick_1hz = 1'b1;
    @(negedge clk);
    sw = 4'b1000; tick_1hz = 1'b0;
    cycles(2);
    repeat (3) pulse_tick();
    check("restart_t3", 64'(page4), 64'(PG_TIME));
    pulse_tick();
    check("restart_t4", 64'(page4), 64'(PG_WDAY));

    // Unsynchronised blink, then resync during a blank phase.
    sw = 4'b0000;
    cycles(2);
    sync_ok = 1'b0;
    repeat (3) pulse_tick();
    for (int k = 0; k < 2 && !m_phase; k++) pulse_tick();
    check("blink_blank", 64'(hex4), 64'(28'hFFFFFFF));
    sync_ok = 1'b1;
    cycles(1);
    check("resync_hex", 64'(hex4), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    // Edge glyphs.
    dt.hour = 8'h08;
    cycles(1);
    check("lz_blank", 64'(hex4), 64'({7'h7F, 7'h00, 7'h30, 7'h19}));
    dt.minute = 8'hA4;
    cycles(1);
    check("bad_bcd", 64'(hex4), 64'({7'h7F, 7'h00, 7'h3F, 7'h19}));
    dt.minute = 8'h34;
    dt.day_of_week = 4'd0;
    sw = 4'b0010;
    cycles(2);
    check("wday_none", 64'(hex4), 64'({7'h3F, 7'h3F, 7'h40, 7'h78}));
    dt.day_of_week = 4'd5;
    cycles(1);
    check("wday_fr", 64'(hex4), 64'({7'h0E, 7'h2F, 7'h40, 7'h78}));

    // Six-digit instance.
    dt.hour = 8'h23; dt.minute = 8'h59; dt.second = 8'h58;
    sw = 4'b0000;
    cycles(2);
    check("six_time", 64'(hex6), 64'({7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00}));
    sw = 4'b0100;
    cycles(2);
    check("six_year", 64'(hex6), 64'({7'h24, 7'h40, 7'h24, 7'h19, 7'h40, 7'h30}));

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1 check("async_blank6", 64'(hex6), 64'(42'h3FFFFFFFFFF));
    check("async_page6", 64'(page6), 64'(PG_TIME));
    cycles(2);
    reset = 1'b0;
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_pager.md
Name: display_pager

Overview:
- Parametrised successor to the fixed 4-digit HEX decoder; drives N_DIGITS active-low seven-segment digits from the if_date_time clock interface.
- Adds:
  - auto-rotating pages with programmable dwell
  - blinking while the DCF77 receiver is unsynchronised
  - hour leading-zero suppression
  - invalid-BCD flagging
  - registered outputs
- Sits between the clock module and board HEX pins.

Parameters:
- N_DIGITS, 4, number of digits driven; legal values 4 or 6 (elaboration error otherwise).
- DWELL_S, 4, seconds each page is shown in auto mode; legal range 1..15.
- LZ_SUPPRESS, 1, when 1 a hour-tens digit of 0 is blanked.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  single-cycle 1 Hz enable pulse from the clock module.
- sync_ok  in  1  1 = receiver has a valid decoded time.
- sw  in  4  sw[2:0] manual page select (priority sw[0] > sw[1] > sw[2]); sw[3] = 1 enables auto-rotate.
- clock  if_date_time  -  BCD date/time (second, minute, hour, day, month, year pairs, day_of_week).
- hex  out  N_DIGITS x 7  active-low segments GFEDCBA; hex[N_DIGITS-1] is leftmost.
- page  out  2  current page_t, for debug/LEDs.

Behaviour:
- Reset:
  - hex = all 7'h7F (blank).
  - page = PG_TIME.
  - dwell counter = 0.
  - blink phase = 0.
- Pages (leftmost first):
  - PG_TIME:
    - N=4: hh mm.
    - N=6: hh mm ss.
  - PG_SEC:
    - N=4: blank blank ss.
    - N=6: blank blank blank blank ss.
  - PG_WDAY:
    - N=4: weekday chars (2 digits), dd.
    - N=6: weekday chars, dd, mm.
  - PG_YEAR:
    - N=4: yy mm.
    - N=6: 2 0 yy mm.
- Manual mode (sw[3]=0):
  - sw[0] selects PG_SEC, sw[1] PG_WDAY, sw[2] PG_YEAR, none set selects PG_TIME.
  - page register updates the cycle after sw changes.
- Auto mode (sw[3]=1):
  - sw[2:0] ignored.
  - Dwell counter increments on tick_1hz.
  - When the counter reaches DWELL_S-1 and tick_1hz is high, page advances and counter clears.
  - Sequence: PG_TIME -> PG_WDAY -> PG_YEAR -> PG_TIME. PG_SEC is never auto-shown.
  - Entering auto mode from manual: counter clears; rotation starts from the current page, or from PG_TIME if the current page is PG_SEC.
  - Leaving auto mode: counter clears; manual selection applies next cycle.
- Blink phase:
  - Toggles on every tick_1hz.
  - If sync_ok=0 and phase=1, all hex digits are 7'h7F. Otherwise page content is shown.
  - When sync_ok rises, the display is steady from the next cycle; phase keeps toggling but is ignored.
- Glyphs:
  - BCD digit 0-9 uses standard glyphs.
  - A nibble >9 in any numeric field shows SEG_DASH (only G lit, 7'h3F).
- Weekday codes: 0 "--", 1 Mo, 2 tu, 3 WE, 4 th, 5 Fr, 6 SA, 7 So.
- Leading zero: with LZ_SUPPRESS=1 and hour tens = 0, the hour-tens digit is blank on PG_TIME only.
- Latency:
  - hex is a registered function of the page register and interface inputs: 1 clk from input change to hex.
  - Page changes reach hex 2 clk after the causing sw/tick edge.
- Simultaneous events: a sw[3] change coincident with tick_1hz means the mode change wins and the counter clears. Phase still toggles.
- Reset mid-rotation returns immediately (asynchronously) to the reset values.

Decomposition:
- Package types:
  - page_t enum {PG_TIME, PG_SEC, PG_WDAY, PG_YEAR}.
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F constants.
  - The weekday glyph table as a constant array.
  - Reuse the existing bcd_t.
- One combinational sub-module, seg7_glyph: bcd_t in -> 7-bit active-low glyph, dash for >9. Instantiated once per numeric digit.
- The page FSM and blink/dwell counters stay in display_pager.

Test Plan:
- Reset with clock = 12:34:56, sync_ok=1, sw=0, N=4 -> hex blank during reset; 1 clk after release hex = "1","2","3","4" (7'h79,7'h24,7'h30,7'h19).
- Manual priority: sw=3'b110, date Tue 07.03.24 -> page=PG_WDAY, hex = t,u,0,7. Then set sw[0] -> PG_SEC, hex = blank,blank,5,6.
- Auto: sw[3]=1, DWELL_S=4, 13 tick_1hz pulses -> page sequence TIME(4 ticks), WDAY(4), YEAR(4), TIME; PG_SEC never appears; toggling sw[3] mid-dwell restarts the count.
- Unsync blink: sync_ok=0 with ticks -> hex alternates blank / content on each tick; raise sync_ok during a blank phase -> content restored the next clk.
- Edge glyphs: hour=08 with LZ_SUPPRESS=1 -> leftmost blank, next "8"; minute tens=4'hA -> SEG_DASH; day_of_week=0 -> "--".
- N_DIGITS=6: time 23:59:58 -> six digits 2,3,5,9,5,8; PG_YEAR shows 2,0,2,4,0,3; async reset asserted mid-cycle blanks all six digits immediately.
